// File: rtl/dino_pkg.sv
// Shared types and jump-physics constants for the Dino jump controller.
// The rise/fall profile is symmetric: 124 rows up, then 124 rows back down.
package dino_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    AIR  = 1'b1
  } jump_state_t;

  localparam int JUMP_STEPS = 64;

  localparam logic [6:0] STEP_RISE_MID = 7'd10;
  localparam logic [6:0] STEP_RISE_TOP = 7'd20;
  localparam logic [6:0] STEP_FALL     = 7'd32;
  localparam logic [6:0] STEP_FALL_MID = 7'd44;
  localparam logic [6:0] STEP_FALL_BOT = 7'd54;
  localparam logic [6:0] STEP_END      = 7'(JUMP_STEPS);

  // Negative deltas move the sprite up the screen.
  function automatic logic signed [3:0] jump_delta(input logic [5:0] step);
    logic [6:0] s;
    s = {1'b0, step};
    if (s < STEP_RISE_MID)      return -4'sd6;
    else if (s < STEP_RISE_TOP) return -4'sd4;
    else if (s < STEP_FALL)     return -4'sd2;
    else if (s < STEP_FALL_MID) return 4'sd2;
    else if (s < STEP_FALL_BOT) return 4'sd4;
    else                        return 4'sd6;
  endfunction

endpackage

// File: rtl/dino_jump_lane.sv
// One dinosaur lane: IDLE/AIR FSM, step counter, one-deep re-jump buffer,
// Y position and leg-animation phase. All strobes are gated by pause.
module dino_jump_lane
  import dino_pkg::*;
#(
  parameter int             Y_W      = 9,
  parameter logic [Y_W-1:0] GROUND   = '0,
  parameter logic           LEG_INIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           anim_tick,
  input  logic           pause,
  input  logic           jump_req,
  output logic [Y_W-1:0] dino_y,
  output logic           airborne,
  output logic           leg,
  output logic           land
);

  jump_state_t    r_state, w_state_nx;
  logic [5:0]     r_step, w_step_nx;
  logic           r_pending, w_pending_nx;
  logic [Y_W-1:0] r_y, w_y_nx;
  logic           r_leg, w_leg_nx;
  logic           r_land, w_land_nx;

  logic              w_tick, w_anim, w_req, w_last, w_falling;
  logic signed [3:0] w_delta;
  logic [Y_W-1:0]    w_delta_ext;

  assign w_tick      = tick & ~pause;
  assign w_anim      = anim_tick & ~pause;
  assign w_req       = jump_req & ~pause;
  assign w_last      = ({1'b0, r_step} == (STEP_END - 7'd1));
  assign w_falling   = ({1'b0, r_step} >= STEP_FALL);
  assign w_delta     = jump_delta(r_step);
  assign w_delta_ext = {{(Y_W-4){w_delta[3]}}, w_delta};

  always_comb begin
    w_state_nx   = r_state;
    w_step_nx    = r_step;
    w_pending_nx = r_pending;
    w_y_nx       = r_y;
    w_leg_nx     = r_leg;
    w_land_nx    = 1'b0;
    case (r_state)
      IDLE: begin
        // Accepting cycle never moves Y, even with a coincident tick.
        if (w_req) begin
          w_state_nx = AIR;
          w_step_nx  = '0;
        end
        if (w_anim) w_leg_nx = ~r_leg;
      end
      AIR: begin
        if (w_tick && w_last) begin
          w_y_nx    = GROUND;
          w_land_nx = 1'b1;
          w_step_nx = '0;
          // A request on the landing tick counts as a buffered re-jump.
          if (r_pending || w_req) w_pending_nx = 1'b0;
          else                    w_state_nx   = IDLE;
        end else begin
          if (w_tick) begin
            w_y_nx    = r_y + w_delta_ext;
            w_step_nx = r_step + 6'd1;
          end
          if (w_req && w_falling) w_pending_nx = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_pending <= 1'b0;
      r_y       <= GROUND;
      r_leg     <= LEG_INIT;
      r_land    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_step    <= w_step_nx;
      r_pending <= w_pending_nx;
      r_y       <= w_y_nx;
      r_leg     <= w_leg_nx;
      r_land    <= w_land_nx;
    end
  end

  assign dino_y   = r_y;
  assign airborne = (r_state == AIR);
  assign leg      = r_leg;
  assign land     = r_land;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Multi-lane jump controller: N_CH independent lanes, each resting
// LANE_PITCH rows below the previous one, with packed Y outputs.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int Y_W        = 9,
  parameter int GROUND_Y   = 146,
  parameter int LANE_PITCH = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              anim_tick,
  input  logic              pause,
  input  logic [N_CH-1:0]   jump_req,
  output logic [N_CH*Y_W-1:0] dino_y,
  output logic [N_CH-1:0]   airborne,
  output logic [N_CH-1:0]   leg,
  output logic [N_CH-1:0]   land
);

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    localparam int LANE_GND = GROUND_Y + g * LANE_PITCH;

    // Alternate starting leg phase so neighbouring dinos do not run in sync.
    dino_jump_lane #(
      .Y_W     (Y_W),
      .GROUND  (Y_W'(LANE_GND)),
      .LEG_INIT((g % 2) != 0)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .anim_tick(anim_tick),
      .pause    (pause),
      .jump_req (jump_req[g]),
      .dino_y   (dino_y[g*Y_W +: Y_W]),
      .airborne (airborne[g]),
      .leg      (leg[g]),
      .land     (land[g])
    );
  end

endmodule

// File: doc/dino_jump_ctrl.md
# dino_jump_ctrl

Parametrised multi-lane jump-physics controller for the Dino game. It tracks the vertical position, airborne state and leg-animation phase for N_CH independent dinosaurs, each driven by its own jump-request pulse. The block sits between the keypad decoder, which supplies the request pulses, and the VGA pixel mux, which consumes `dino_y` and `leg`. It adds two behaviours the game needs: one-deep buffering of a re-jump request, and a global pause.

## Interface
- N_CH, 2: number of independent lanes.
- Y_W, 9: width of each Y coordinate (row address width).
- GROUND_Y, 146: resting top-left Y of lane 0.
- LANE_PITCH, 240: Y offset between consecutive lanes; lane i rests at GROUND_Y + i*LANE_PITCH.

- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- tick  input  1  one-cycle motion strobe, nominally about 95 Hz.
- anim_tick  input  1  one-cycle leg-animation strobe.
- pause  input  1  level signal; freezes motion and animation.
- jump_req  input  N_CH  one-cycle request per lane, already edge-detected.
- dino_y  output  N_CH*Y_W  current top-left Y; lane i occupies bits [i*Y_W +: Y_W].
- airborne  output  N_CH  lane is currently in a jump.
- leg  output  N_CH  leg sprite select: 0 = left sprite, 1 = right sprite.
- land  output  N_CH  one-cycle pulse on the landing tick.

## Operation
- Each lane has two states, IDLE and AIR, plus a 6-bit step counter (0..63) and a single `pending` flag.
- **IDLE + jump_req, pause = 0:**
  - Go to AIR with step = 0.
  - Y does not change in the accepting cycle, even if `tick` is asserted in the same cycle.
- **AIR + tick, pause = 0:**
  - Y ← Y + delta(step), then step ← step + 1.
  - delta by step range:
    - steps 0–9: −6
    - steps 10–19: −4
    - steps 20–31: −2
    - steps 32–43: +2
    - steps 44–53: +4
    - steps 54–63: +6
  - Total rise is 124 and total fall is 124, so the peak is GROUND−124 and the lane lands exactly on its ground value.
  - Arithmetic is modulo 2^Y_W. No clamping is required; the parameters guarantee the result is never negative.
- **Landing tick (the tick applied at step 63):**
  - Y returns to the lane's ground value and `land` pulses.
  - If `pending` = 1: clear `pending` and stay in AIR with step = 0, so the re-jump's first rise happens on the next tick.
  - Otherwise go to IDLE.
- **jump_req while in AIR:**
  - Step ≥ 32 (falling): set `pending`. Further requests are absorbed; the buffer is one deep.
  - Step < 32 (rising): drop the request.
- **jump_req arriving in the same cycle as the landing tick:** counts as a falling-phase request, so the re-jump occurs.
- **Leg animation:** `leg` toggles on `anim_tick` only in IDLE with pause = 0. It is held constant while in AIR.
- **pause = 1:**
  - `tick`, `anim_tick` and `jump_req` are all ignored.
  - Y, step and `pending` are frozen.
- `airborne` = (state == AIR).
- Lanes are fully independent; simultaneous requests on different lanes are all served.

## Timing
- Every output is registered and updates in the cycle after the qualifying strobe (1-cycle latency).
- A jump lasts 64 ticks from the first movement tick.
- Request-to-first-motion takes 1 tick period after acceptance.
- Reset values (asynchronous, taken immediately):
  - state IDLE, step 0, pending 0
  - dino_y[i] = GROUND_Y + i*LANE_PITCH
  - airborne 0, land 0
  - leg[i] = i[0], so adjacent lanes start in opposite leg phase
- Reset mid-jump drops the lane to ground immediately and discards `pending`.
- `land` is high for exactly one clk cycle and is never asserted while pause = 1.

## Structure
- Package `dino_pkg` holds:
  - state enum `jump_state_t` {IDLE, AIR}
  - step-boundary constants 10/20/32/44/54/64
  - function `jump_delta(step)` returning a signed 4-bit value
  - constant JUMP_STEPS = 64
- Sub-module `dino_jump_lane` implements one lane (FSM, step counter, pending flag, Y register, leg register). It is parametrised by Y_W and a ground value.
- The top level instantiates N_CH lanes in a generate loop and packs `dino_y`.

## Test plan
- **Reset defaults:** N_CH = 2, release rst → dino_y = {386, 146}, airborne = 00, leg = 10, land = 00.
- **Full jump profile:** jump_req[0], then 64 ticks → Y of lane 0 after ticks 10/20/32 = 86/46/22 (peak), after tick 64 = 146. land[0] pulses once at tick 64; airborne[0] clears the following cycle.
- **Request filtering and buffering:** jump_req[0] at step 5 is dropped. A request at step 40 sets `pending`; at landing Y = 146, land pulses, airborne stays 1, and the next tick gives Y = 140.
- **Simultaneous events:** jump_req and tick in the same IDLE cycle → Y unchanged that cycle; the next tick moves Y by −6. Requests on both lanes in the same cycle → both jump in lockstep with a 240 Y offset.
- **Pause mid-jump:** assert pause at step 15 (Y = 66) for 20 ticks → Y stays 66, requests are ignored, leg is frozen. After release, the jump completes and lands at 146 after 49 more ticks.
- **Reset mid-jump:** assert rst at step 25 (Y = 36) with pending = 0 → Y = 146 and airborne = 0 immediately, with no land pulse.
